// File: rtl/msg_block_word_sched.sv
// Buffers one 512-bit padded block in a 16-word sliding window and streams it to the
// SHA-256 compression core one word per handshake. Define SCHEDULE_EXPAND_EN to also emit W16..W63.
module msg_block_word_sched #(
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              block_valid,
  output logic                              block_ready,
  input  logic [BLOCK_WORDS*WORD_WIDTH-1:0] message_vector,
  input  logic                              block_last,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [WORD_WIDTH-1:0]             word_data,
  output logic [5:0]                        word_index,
  output logic                              word_last,
  output logic                              word_msg_last,
  output logic                              busy
);

  typedef enum logic {IDLE, EMIT} state_t;

`ifdef SCHEDULE_EXPAND_EN
  localparam logic [5:0] LAST = 6'd63;
`else
  localparam logic [5:0] LAST = 6'd15;
`endif

  state_t                state;
  logic [WORD_WIDTH-1:0] window [BLOCK_WORDS];
  logic [5:0]            index;
  logic                  msg_last;
  logic [WORD_WIDTH-1:0] tail;

`ifdef SCHEDULE_EXPAND_EN
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Window holds W[t..t+15], so the new tail is W[t+16].
  assign tail = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
`else
  assign tail = '0;
`endif

  // NOTE: block_ready is decoded from the state register and reset, not registered, so an
  // upstream source sees it the same cycle the block frees up.
  assign block_ready   = (state == IDLE) && !reset;
  assign word_valid    = (state == EMIT);
  assign word_data     = window[0];
  assign word_index    = index;
  assign word_last     = word_valid && (index == LAST);
  assign word_msg_last = word_last && msg_last;
  assign busy          = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      index    <= '0;
      msg_last <= 1'b0;
      // NOTE: the window is a register file cleared on reset so a discarded block can
      // never leak onto word_data; it is small enough that this costs nothing real.
      for (int i = 0; i < BLOCK_WORDS; i++) window[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (block_valid && block_ready) begin
            for (int i = 0; i < BLOCK_WORDS; i++)
              window[i] <= message_vector[(BLOCK_WORDS-1-i)*WORD_WIDTH +: WORD_WIDTH];
            msg_last <= block_last;
            index    <= '0;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (word_ready) begin
            if (index == LAST) begin
              state <= IDLE;
            end else begin
              for (int i = 0; i < BLOCK_WORDS-1; i++) window[i] <= window[i+1];
              window[BLOCK_WORDS-1] <= tail;
              index <= index + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
